// File: rtl/c_fetch_seq.sv
// c_fetch_seq: instruction fetch sequencer for a mixed 16/32-bit ISA.
// Reads aligned 32-bit words and emits one instruction per cycle. A 32-bit
// instruction may straddle two words; compressed ones sit in either halfword.
// Ports:
//   clk, reset        - clock and synchronous active-low reset
//   imem_addr_o/req_o - word-aligned fetch address and request
//   imem_rdata_i/valid_i - fetch data, returned in the same cycle
//   br_taken_i/br_target_i - redirect from execute
//   dec_stall_i       - decoder back-pressure
//   inst_o/valid_o/pc_o/c_o - registered instruction output
module c_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr_o,
  output logic        imem_req_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_valid_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        dec_stall_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_c_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned HW   = 16;

  // ALIGNED: pc_q on a word boundary, nothing buffered.
  // HALF:    pc_q on the upper halfword, that halfword is held in hold_q.
  // SKIP_LO: redirected to an upper halfword, its word not yet fetched.
  typedef enum logic [1:0] {
    ST_ALIGNED = 2'd0,
    ST_HALF    = 2'd1,
    ST_SKIP_LO = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_c_q, inst_c_d;
  logic            inst_valid_q, inst_valid_d;

  logic stalled;
  logic hold_is_c;
  logic lo_is_c;
  logic accept;

  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_c_o     = inst_c_q;

  // Fetch address/request and halfword classification.
  always_comb begin
    stalled     = inst_valid_q & dec_stall_i;
    hold_is_c   = (hold_q[1:0] != 2'b11);
    lo_is_c     = (imem_rdata_i[1:0] != 2'b11);
    imem_addr_o = {pc_q[XLEN-1:2], 2'b00};
    if (state_q == ST_HALF) begin
      imem_addr_o = {pc_q[XLEN-1:2] + 30'd1, 2'b00};
    end
    // In HALF with a compressed hold_q the next instruction needs no memory.
    imem_req_o  = ~stalled & ~br_taken_i & ((state_q != ST_HALF) | ~hold_is_c);
    accept      = imem_req_o & imem_valid_i;
  end

  // Next-state and output computation.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_c_d     = inst_c_q;
    inst_valid_d = inst_valid_q;

    if (br_taken_i) begin
      inst_valid_d = 1'b0;
      pc_d         = br_target_i & ~32'd1;
      hold_d       = '0;
      state_d      = br_target_i[1] ? ST_SKIP_LO : ST_ALIGNED;
    end else if (!stalled) begin
      inst_valid_d = 1'b0;
      unique case (state_q)
        ST_ALIGNED: begin
          if (accept) begin
            inst_valid_d = 1'b1;
            inst_pc_d    = pc_q;
            if (lo_is_c) begin
              inst_d   = {16'h0000, imem_rdata_i[15:0]};
              inst_c_d = 1'b1;
              pc_d     = pc_q + 32'd2;
              hold_d   = imem_rdata_i[31:16];
              state_d  = ST_HALF;
            end else begin
              inst_d   = imem_rdata_i;
              inst_c_d = 1'b0;
              pc_d     = pc_q + 32'd4;
            end
          end
        end
        ST_HALF: begin
          if (hold_is_c) begin
            inst_valid_d = 1'b1;
            inst_pc_d    = pc_q;
            inst_d       = {16'h0000, hold_q};
            inst_c_d     = 1'b1;
            pc_d         = pc_q + 32'd2;
            state_d      = ST_ALIGNED;
          end else if (accept) begin
            inst_valid_d = 1'b1;
            inst_pc_d    = pc_q;
            inst_d       = {imem_rdata_i[15:0], hold_q};
            inst_c_d     = 1'b0;
            pc_d         = pc_q + 32'd4;
            hold_d       = imem_rdata_i[31:16];
          end
        end
        ST_SKIP_LO: begin
          // Low half belongs to the previous stream; keep only the upper half.
          if (accept) begin
            hold_d  = imem_rdata_i[31:16];
            state_d = ST_HALF;
          end
        end
        default: begin
          state_d = ST_ALIGNED;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_ALIGNED;
      pc_q         <= RESET_PC;
      hold_q       <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_c_q     <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_q       <= hold_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_c_q     <= inst_c_d;
      inst_valid_q <= inst_valid_d;
    end
  end

endmodule

// File: tb/tb_c_fetch_seq.sv
// Testbench for c_fetch_seq: directed scenarios plus a randomized run checked
// against an instruction-stream model built from a flat memory image.
module tb_c_fetch_seq;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        br_taken;
  logic [31:0] br_target;
  logic        dec_stall;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic        inst_c;

  logic [31:0] mem [1024];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[11:2]];

  c_fetch_seq #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_addr_o  (imem_addr),
    .imem_req_o   (imem_req),
    .imem_rdata_i (imem_rdata),
    .imem_valid_i (imem_valid),
    .br_taken_i   (br_taken),
    .br_target_i  (br_target),
    .dec_stall_i  (dec_stall),
    .inst_o       (inst),
    .inst_valid_o (inst_valid),
    .inst_pc_o    (inst_pc),
    .inst_c_o     (inst_c)
  );

  // Halfword of the memory image at a halfword address.
  function automatic logic [15:0] ref_hw(input logic [31:0] pc);
    logic [31:0] w;
    w = mem[pc[11:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  // Instruction starting at pc according to the ISA length rule.
  task automatic ref_inst(input logic [31:0] pc, output logic [31:0] ins,
                          output logic c);
    logic [15:0] lo;
    lo = ref_hw(pc);
    c  = (lo[1:0] != 2'b11);
    if (c) ins = {16'h0000, lo};
    else   ins = {ref_hw(pc + 32'd2), lo};
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013;
  endtask

  task automatic do_reset();
    reset = 1'b0; br_taken = 1'b0; dec_stall = 1'b0; imem_valid = 1'b1;
    br_target = '0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; br_taken = 1'b1; br_target = 32'h0000_0802;
    dec_stall = 1'b1; imem_valid = 1'b1;
    tick(); tick();
    br_taken = 1'b0; dec_stall = 1'b0;
    #1;
    n_tests++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || inst_c !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b inst=%h pc=%h c=%b, want 0/0/0/0",
               inst_valid, inst, inst_pc, inst_c);
    end
    n_tests++;
    if (imem_addr !== RST_PC || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_fetch: addr=%h req=%b, want %h/1", imem_addr, imem_req, RST_PC);
    end
    reset = 1'b1;
  endtask

  task automatic test_mixed();
    clear_mem();
    mem[0] = 32'h006f_c104; mem[1] = 32'h4104_0040;
    do_reset();
    tick();
    n_tests++;
    if (inst_valid !== 1'b1 || inst !== 32'h0000_c104 || inst_c !== 1'b1 || inst_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL mixed_0: v=%b inst=%h c=%b pc=%h, want 1/0000c104/1/0", inst_valid, inst, inst_c, inst_pc);
    end
    tick();
    n_tests++;
    if (inst_valid !== 1'b1 || inst !== 32'h0040_006f || inst_c !== 1'b0 || inst_pc !== 32'h2) begin
      n_fail++;
      $display("FAIL mixed_1: v=%b inst=%h c=%b pc=%h, want 1/0040006f/0/2", inst_valid, inst, inst_c, inst_pc);
    end
    n_tests++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL mixed_noreq: req=%b, want 0", imem_req);
    end
    tick();
    n_tests++;
    if (inst_valid !== 1'b1 || inst !== 32'h0000_4104 || inst_c !== 1'b1 || inst_pc !== 32'h6) begin
      n_fail++;
      $display("FAIL mixed_2: v=%b inst=%h c=%b pc=%h, want 1/00004104/1/6", inst_valid, inst, inst_c, inst_pc);
    end
    n_tests++;
    if (imem_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL mixed_addr: addr=%h, want 8", imem_addr);
    end
  endtask

  task automatic test_aligned();
    clear_mem();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (inst_valid !== 1'b1 || inst !== 32'h13 || inst_c !== 1'b0 || inst_pc !== 32'(4 * i)) begin
        n_fail++;
        $display("FAIL aligned_%0d: v=%b inst=%h c=%b pc=%h, want 1/13/0/%h",
                 i, inst_valid, inst, inst_c, inst_pc, 32'(4 * i));
      end
    end
  endtask

  task automatic test_branch();
    clear_mem();
    mem[64] = 32'h0001_c104;
    do_reset();
    tick();
    br_taken = 1'b1; br_target = 32'h0000_0103;
    tick();
    br_taken = 1'b0;
    #1;
    n_tests++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_redirect: v=%b addr=%h req=%b, want 0/100/1", inst_valid, imem_addr, imem_req);
    end
    tick();
    n_tests++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_bubble: v=%b, want 0", inst_valid);
    end
    tick();
    n_tests++;
    if (inst_valid !== 1'b1 || inst !== 32'h1 || inst_c !== 1'b1 || inst_pc !== 32'h102) begin
      n_fail++;
      $display("FAIL branch_inst: v=%b inst=%h c=%b pc=%h, want 1/1/1/102", inst_valid, inst, inst_c, inst_pc);
    end
  endtask

  task automatic test_stall();
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = 32'h0000_0013 | 32'(i << 7);
    do_reset();
    tick();
    dec_stall = 1'b1;
    #1;
    n_tests++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_req: req=%b, want 0", imem_req);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (inst_valid !== 1'b1 || inst !== 32'h13 || inst_pc !== 32'h0) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: v=%b inst=%h pc=%h, want 1/13/0", i, inst_valid, inst, inst_pc);
      end
    end
    dec_stall = 1'b0;
    tick();
    n_tests++;
    if (inst_valid !== 1'b1 || inst !== 32'h93 || inst_pc !== 32'h4) begin
      n_fail++;
      $display("FAIL stall_resume: v=%b inst=%h pc=%h, want 1/93/4", inst_valid, inst, inst_pc);
    end
  endtask

  task automatic test_valid_gap();
    clear_mem();
    mem[0] = 32'h006f_c104; mem[1] = 32'h4104_0040;
    do_reset();
    tick();
    imem_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (inst_valid !== 1'b0 || imem_addr !== 32'h4 || dut.pc_q !== 32'h2 || dut.hold_q !== 16'h006f) begin
        n_fail++;
        $display("FAIL gap_hold_%0d: v=%b addr=%h pc_q=%h hold_q=%h, want 0/4/2/006f",
                 i, inst_valid, imem_addr, dut.pc_q, dut.hold_q);
      end
    end
    imem_valid = 1'b1;
    tick();
    n_tests++;
    if (inst_valid !== 1'b1 || inst !== 32'h0040_006f || inst_c !== 1'b0 || inst_pc !== 32'h2) begin
      n_fail++;
      $display("FAIL gap_resume: v=%b inst=%h c=%b pc=%h, want 1/0040006f/0/2", inst_valid, inst, inst_c, inst_pc);
    end
  endtask

  task automatic test_reset_in_half();
    clear_mem();
    mem[0] = 32'h006f_c104;
    do_reset();
    tick();
    reset = 1'b0; br_taken = 1'b1; br_target = 32'h0000_0202; dec_stall = 1'b1;
    tick();
    reset = 1'b1; br_taken = 1'b0; dec_stall = 1'b0;
    #1;
    n_tests++;
    if (inst_valid !== 1'b0 || imem_addr !== RST_PC || dut.pc_q !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_half: v=%b addr=%h pc_q=%h, want 0/%h/%h",
               inst_valid, imem_addr, dut.pc_q, RST_PC, RST_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, exp_inst;
    logic        exp_c;
    logic        bad_out, bad_req;
    int          emitted;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    do_reset();
    exp_pc  = RST_PC;
    emitted = 0;
    bad_out = 1'b0;
    bad_req = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      ref_inst(exp_pc, exp_inst, exp_c);
      if (inst_valid === 1'b1 &&
          (inst_pc !== exp_pc || inst !== exp_inst || inst_c !== exp_c) && !bad_out) begin
        bad_out = 1'b1;
        $display("FAIL rand_inst cyc %0d: inst=%h c=%b pc=%h, want %h/%b/%h",
                 cyc, inst, inst_c, inst_pc, exp_inst, exp_c, exp_pc);
      end
      imem_valid = ($urandom_range(0, 3) != 0);
      dec_stall  = ($urandom_range(0, 3) == 0);
      br_taken   = ($urandom_range(0, 39) == 0);
      br_target  = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                               : 32'($urandom_range(0, 4095));
      #1;
      if (((br_taken || (inst_valid && dec_stall)) && imem_req !== 1'b0 ||
           imem_addr[1:0] !== 2'b00) && !bad_req) begin
        bad_req = 1'b1;
        $display("FAIL rand_req cyc %0d: req=%b addr=%h br=%b v=%b stall=%b, want req 0 / aligned",
                 cyc, imem_req, imem_addr, br_taken, inst_valid, dec_stall);
      end
      if (br_taken) begin
        exp_pc = br_target & ~32'd1;
      end else if (inst_valid && !dec_stall) begin
        exp_pc = exp_pc + (exp_c ? 32'd2 : 32'd4);
        emitted++;
      end
      tick();
    end
    br_taken = 1'b0; dec_stall = 1'b0;
    n_tests++;
    if (bad_out) n_fail++;
    n_tests++;
    if (bad_req) n_fail++;
    n_tests++;
    if (emitted < 500) begin
      n_fail++;
      $display("FAIL rand_progress: emitted=%0d, want >= 500", emitted);
    end
  endtask

  initial begin
    reset = 1'b0; br_taken = 1'b0; br_target = '0; dec_stall = 1'b0; imem_valid = 1'b0;
    clear_mem();
    @(negedge clk);
    test_reset();
    test_mixed();
    test_aligned();
    test_branch();
    test_stall();
    test_valid_gap();
    test_reset_in_half();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
